// File: rtl/oc8051_ifetch_pkg.sv
// Shared constants, state encoding and helpers for the instruction prefetch unit.
package oc8051_ifetch_pkg;

  localparam int unsigned OC8051_IFQ_DEPTH = 8;
  localparam logic [15:0] OC8051_RST_VEC   = 16'h0000;
  localparam int unsigned OC8051_ROM_LAT   = 1;
  localparam int unsigned WORD_BYTES       = 4;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_FAULT = 1'b1
  } ifetch_state_e;

  // Bytes the decoder may actually retire: never more than the queue holds.
  function automatic logic [1:0] min_consume(input logic [1:0] req,
                                             input logic [7:0] cnt);
    if ({6'd0, req} > cnt) begin
      return cnt[1:0];
    end
    return req;
  endfunction

endpackage

// File: rtl/oc8051_ifq_buf.sv
// Byte circular buffer: 4-byte tail write, 3-byte head read, count tracking.
module oc8051_ifq_buf
  import oc8051_ifetch_pkg::*;
#(
  parameter  int unsigned DEPTH = OC8051_IFQ_DEPTH,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          wr_en_i,
  input  logic [31:0]   wr_data_i,
  input  logic [1:0]    adv_i,
  output logic [CW-1:0] count_o,
  output logic [23:0]   head_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  // Pointer and count update; flush empties the queue and ignores advance/write.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = tail_q;
      count_d = '0;
    end else begin
      head_d  = head_q + PW'(adv_i);
      count_d = count_q - CW'(adv_i);
      if (wr_en_i) begin
        tail_d  = tail_q + PW'(WORD_BYTES);
        count_d = count_d + CW'(WORD_BYTES);
      end
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Byte storage; contents beyond count are never presented, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en_i && !flush_i) begin
      for (int unsigned i = 0; i < WORD_BYTES; i++) begin
        mem_q[tail_q + PW'(i)] <= wr_data_i[8*i +: 8];
      end
    end
  end

  // Head window: bytes past the valid count read as zero.
  always_comb begin
    head_o = '0;
    for (int unsigned i = 0; i < 3; i++) begin
      if (CW'(i) < count_q) begin
        head_o[8*i +: 8] = mem_q[head_q + PW'(i)];
      end
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/oc8051_ifetch.sv
// Instruction prefetch unit: issues ROM word fetches, fills the byte queue,
// and presents opcode + operands with their PC to the decoder.
module oc8051_ifetch
  import oc8051_ifetch_pkg::*;
#(
  parameter  int unsigned QDEPTH  = OC8051_IFQ_DEPTH,
  parameter  logic [15:0] RST_VEC = OC8051_RST_VEC,
  localparam int unsigned CW      = $clog2(QDEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic [15:0]   rom_addr,
  input  logic [31:0]   rom_data,
  input  logic          ea_int,
  input  logic          jmp,
  input  logic [15:0]   jmp_addr,
  input  logic [1:0]    consume,
  output logic [CW-1:0] q_count,
  output logic [23:0]   q_bytes,
  output logic [15:0]   q_pc,
  output logic          rom_fault
);

  ifetch_state_e state_q, state_d;
  logic [15:0]   fetch_ptr_q, fetch_ptr_d;
  logic [15:0]   pc_q, pc_d;
  logic          inflight_q, inflight_d;

  logic [1:0]    consume_eff;
  logic [CW+1:0] occupancy;
  logic          fits;
  logic          capture;
  logic          cap_ok;
  logic          cap_fault;
  logic          issue;

  assign consume_eff = min_consume(consume, 8'(q_count));
  assign rom_addr    = jmp ? jmp_addr : fetch_ptr_q;

  // Space check: bytes left after retiring, plus the word already in flight,
  // plus the word a new request would bring.
  always_comb begin
    occupancy = (CW+2)'(q_count - CW'(consume_eff))
              + (inflight_q ? (CW+2)'(WORD_BYTES) : '0)
              + (CW+2)'(WORD_BYTES);
    fits      = (occupancy <= (CW+2)'(QDEPTH));
  end

  // Next-state, issue and capture decisions; jmp dominates everything.
  // With a one-cycle ROM the kill of a pre-jmp response coincides with jmp itself.
  always_comb begin
    state_d     = state_q;
    fetch_ptr_d = fetch_ptr_q;
    inflight_d  = 1'b0;
    pc_d        = pc_q + 16'(consume_eff);
    capture     = inflight_q && !jmp && (state_q == ST_RUN);
    cap_ok      = capture && ea_int;
    cap_fault   = capture && !ea_int;
    issue       = 1'b0;

    if (jmp) begin
      state_d = ST_RUN;
      issue   = 1'b1;
      pc_d    = jmp_addr;
    end else begin
      unique case (state_q)
        ST_RUN: begin
          if (cap_fault) begin
            state_d = ST_FAULT;
          end else begin
            issue = fits;
          end
        end
        ST_FAULT: begin
          issue = 1'b0;
        end
        default: begin
          state_d = ST_RUN;
        end
      endcase
    end

    if (issue) begin
      inflight_d  = 1'b1;
      fetch_ptr_d = rom_addr + 16'd4;
    end
  end

  // Control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RUN;
      fetch_ptr_q <= RST_VEC;
      pc_q        <= RST_VEC;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_ptr_q <= fetch_ptr_d;
      pc_q        <= pc_d;
      inflight_q  <= inflight_d;
    end
  end

  oc8051_ifq_buf #(
    .DEPTH (QDEPTH)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (jmp),
    .wr_en_i   (cap_ok),
    .wr_data_i (rom_data),
    .adv_i     (consume_eff),
    .count_o   (q_count),
    .head_o    (q_bytes)
  );

  assign q_pc      = pc_q;
  assign rom_fault = (state_q == ST_FAULT);

endmodule

// File: tb/tb_oc8051_ifetch.sv
// Directed bench for the prefetch unit with a one-cycle-latency ROM model
// whose bytes equal the low address byte; 0x1000-0x1FFF is external.
module tb_oc8051_ifetch;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] rom_addr;
  logic [31:0] rom_data;
  logic        ea_int;
  logic        jmp = 1'b0;
  logic [15:0] jmp_addr = 16'h0000;
  logic [1:0]  consume = 2'd0;
  logic [3:0]  q_count;
  logic [23:0] q_bytes;
  logic [15:0] q_pc;
  logic        rom_fault;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  oc8051_ifetch #(
    .QDEPTH  (8),
    .RST_VEC (16'h0000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rom_addr  (rom_addr),
    .rom_data  (rom_data),
    .ea_int    (ea_int),
    .jmp       (jmp),
    .jmp_addr  (jmp_addr),
    .consume   (consume),
    .q_count   (q_count),
    .q_bytes   (q_bytes),
    .q_pc      (q_pc),
    .rom_fault (rom_fault)
  );

  // ROM model: registered address, word assembled from four consecutive bytes.
  logic [15:0] rom_a = 16'h0000;
  always @(posedge clk) rom_a <= rom_addr;
  assign rom_data = {rom_a[7:0] + 8'd3, rom_a[7:0] + 8'd2, rom_a[7:0] + 8'd1, rom_a[7:0]};
  assign ea_int   = (rom_a[15:12] != 4'h1);

  typedef struct {
    logic        jmp;
    logic [15:0] ja;
    logic [1:0]  cons;
    logic [15:0] addr;
    logic [3:0]  cnt;
    logic [23:0] bytes;
    logic [15:0] pc;
    logic        flt;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic j, input logic [15:0] ja, input logic [1:0] c,
                     input logic [15:0] a, input logic [3:0] n, input logic [23:0] b,
                     input logic [15:0] p, input logic f);
    vec_t v;
    v.jmp = j; v.ja = ja; v.cons = c; v.addr = a;
    v.cnt = n; v.bytes = b; v.pc = p; v.flt = f;
    vecs.push_back(v);
  endtask

  task automatic chk_outputs(input string tag, input logic [3:0] n, input logic [23:0] b,
                             input logic [15:0] p, input logic f);
    chk({tag, " q_count"},   32'(q_count),   32'(n));
    chk({tag, " q_bytes"},   32'(q_bytes),   32'(b));
    chk({tag, " q_pc"},      32'(q_pc),      32'(p));
    chk({tag, " rom_fault"}, 32'(rom_fault), 32'(f));
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    //   jmp  target    cons addr      cnt  bytes       pc        flt
    // fill from reset, then stop issuing when full
    add(0, 16'h0000, 0, 16'h0000, 0, 24'h000000, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0004, 4, 24'h020100, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0008, 8, 24'h020100, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0008, 8, 24'h020100, 16'h0000, 0);
    // steady-state consume of 3 with refill, including clamp at count 2
    add(0, 16'h0000, 3, 16'h0008, 5, 24'h050403, 16'h0003, 0);
    add(0, 16'h0000, 3, 16'h0008, 2, 24'h000706, 16'h0006, 0);
    add(0, 16'h0000, 3, 16'h000C, 4, 24'h0A0908, 16'h0008, 0);
    add(0, 16'h0000, 3, 16'h0010, 5, 24'h0D0C0B, 16'h000B, 0);
    add(0, 16'h0000, 3, 16'h0010, 2, 24'h000F0E, 16'h000E, 0);
    add(0, 16'h0000, 3, 16'h0014, 4, 24'h121110, 16'h0010, 0);
    add(0, 16'h0000, 0, 16'h0018, 8, 24'h121110, 16'h0010, 0);
    add(0, 16'h0000, 3, 16'h0018, 5, 24'h151413, 16'h0013, 0);
    add(0, 16'h0000, 3, 16'h0018, 2, 24'h001716, 16'h0016, 0);
    // jmp with word 0x0018 in flight: it must be dropped
    add(1, 16'h0123, 3, 16'h0123, 0, 24'h000000, 16'h0123, 0);
    add(0, 16'h0000, 0, 16'h0127, 4, 24'h252423, 16'h0123, 0);
    add(0, 16'h0000, 0, 16'h012B, 8, 24'h252423, 16'h0123, 0);
    // address wrap at top of the 64K space
    add(1, 16'hFFFE, 0, 16'hFFFE, 0, 24'h000000, 16'hFFFE, 0);
    add(0, 16'h0000, 0, 16'h0002, 4, 24'h00FFFE, 16'hFFFE, 0);
    add(0, 16'h0000, 2, 16'h0006, 6, 24'h020100, 16'h0000, 0);
    add(0, 16'h0000, 0, 16'h0006, 6, 24'h020100, 16'h0000, 0);
    // run into external space: fault, drain, recover on jmp
    add(1, 16'h0FF8, 0, 16'h0FF8, 0, 24'h000000, 16'h0FF8, 0);
    add(0, 16'h0000, 0, 16'h0FFC, 4, 24'hFAF9F8, 16'h0FF8, 0);
    add(0, 16'h0000, 0, 16'h1000, 8, 24'hFAF9F8, 16'h0FF8, 0);
    add(0, 16'h0000, 3, 16'h1000, 5, 24'hFDFCFB, 16'h0FFB, 0);
    add(0, 16'h0000, 3, 16'h1000, 2, 24'h00FFFE, 16'h0FFE, 0);
    add(0, 16'h0000, 0, 16'h1004, 2, 24'h00FFFE, 16'h0FFE, 1);
    add(0, 16'h0000, 0, 16'h1004, 2, 24'h00FFFE, 16'h0FFE, 1);
    add(0, 16'h0000, 3, 16'h1004, 0, 24'h000000, 16'h1000, 1);
    add(0, 16'h0000, 0, 16'h1004, 0, 24'h000000, 16'h1000, 1);
    add(0, 16'h0000, 0, 16'h1004, 0, 24'h000000, 16'h1000, 1);
    add(1, 16'h0040, 0, 16'h0040, 0, 24'h000000, 16'h0040, 0);
    add(0, 16'h0000, 0, 16'h0044, 4, 24'h424140, 16'h0040, 0);
    add(0, 16'h0000, 1, 16'h0048, 7, 24'h434241, 16'h0041, 0);

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk_outputs("reset", 4'd0, 24'h0, 16'h0000, 1'b0);
    chk("reset rom_addr", 32'(rom_addr), 32'h0000);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      jmp      = vecs[i].jmp;
      jmp_addr = vecs[i].ja;
      consume  = vecs[i].cons;
      #1;
      chk($sformatf("v%0d rom_addr", i), 32'(rom_addr), 32'(vecs[i].addr));
      @(posedge clk);
      #1;
      chk_outputs($sformatf("v%0d", i), vecs[i].cnt, vecs[i].bytes, vecs[i].pc, vecs[i].flt);
    end

    // asynchronous reset in the middle of a stream
    jmp = 1'b0;
    consume = 2'd0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_outputs("midrst", 4'd0, 24'h0, 16'h0000, 1'b0);
    chk("midrst rom_addr", 32'(rom_addr), 32'h0000);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    chk("post-rst rom_addr", 32'(rom_addr), 32'h0000);
    @(posedge clk);
    #1;
    chk_outputs("post-rst c1", 4'd0, 24'h0, 16'h0000, 1'b0);
    @(posedge clk);
    #1;
    chk_outputs("post-rst c2", 4'd4, 24'h020100, 16'h0000, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
